// File: rtl/ysyx_23060096_seq_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding and counter width default.
// Pure declarations; no timing or backpressure of its own.
package ysyx_23060096_seq_pkg;

    localparam int STATE_W   = 4;
    localparam int CNT_W_DEF = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        IFETCH = 4'd1,
        IWAIT  = 4'd2,
        DECODE = 4'd3,
        EXEC   = 4'd4,
        MEM    = 4'd5,
        DWAIT  = 4'd6,
        WB     = 4'd7,
        HALT   = 4'd8
    } state_t;

endpackage

// File: rtl/ysyx_23060096_perf_cnt.sv
// Enable-gated wrapping event counter.
// Latency: count visible the cycle after the enabled edge; no backpressure.
// Wraps silently modulo 2^W.
module ysyx_23060096_perf_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ysyx_23060096_mc_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; optional perf counters under YSYX_23060096_SEQ_PERF_EN.
// Latency: 4 cycles ALU, 5 cycles load/store, +1 per memory wait cycle.
// Backpressure: req_valid held until ready; responses waited for in IWAIT/DWAIT.
module ysyx_23060096_mc_seq
    import ysyx_23060096_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    input  logic             dec_reg_wr,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_ebreak,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
`ifdef YSYX_23060096_SEQ_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic             halted
);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:   state <= IFETCH;
                IFETCH: if (imem_req_ready) state <= imem_rsp_valid ? DECODE : IWAIT;
                IWAIT:  if (imem_rsp_valid) state <= DECODE;
                DECODE: state <= EXEC;
                // ebreak takes priority so a halting instruction never touches dmem
                EXEC: begin
                    if (dec_ebreak)                   state <= HALT;
                    else if (dec_mem_rd || dec_mem_wr) state <= MEM;
                    else                              state <= WB;
                end
                MEM:    if (dmem_req_ready) state <= dmem_rsp_valid ? WB : DWAIT;
                DWAIT:  if (dmem_rsp_valid) state <= WB;
                WB:     state <= IFETCH;
                HALT:   state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Request valids depend on state only, so they never glitch with decoder inputs.
    assign imem_req_valid = (state == IFETCH);
    assign dmem_req_valid = (state == MEM);
    assign ir_we  = imem_rsp_valid && (((state == IFETCH) && imem_req_ready) || (state == IWAIT));
    assign pc_we  = (state == WB);
    assign rf_we  = (state == WB) && dec_reg_wr;
    assign halted = (state == HALT);

`ifdef YSYX_23060096_SEQ_PERF_EN
    ysyx_23060096_perf_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != HALT),
        .cnt   (cycle_cnt)
    );

    ysyx_23060096_perf_cnt #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_we),
        .cnt   (instret_cnt)
    );
`endif

endmodule
